// File: rtl/logiana_pkg.sv
// Shared definitions for the logiana host port: FSM encodings, H_MODE register
// selects and the control-byte field layout understood by the logiana core.
package logiana_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_STROBE  = 3'd2;
    localparam state_t ST_HOLD    = 3'd3;
    localparam state_t ST_WAIT_RD = 3'd4;
    localparam state_t ST_GAP     = 3'd5;

    localparam logic MODE_CTRL = 1'b0;  // rate / control / readout
    localparam logic MODE_TRIG = 1'b1;  // trigger setup / readback

    // Control byte written with H_MODE=MODE_CTRL.
    localparam int CTRL_RATE_LSB = 0;
    localparam int CTRL_RATE_W   = 3;
    localparam int CTRL_LAST_BIT = 7;

endpackage

// File: rtl/logiana_host_master_if.sv
// Host-port pins of the logiana core; the master drives strobes, mode and data,
// the slave (core or bench responder) returns H_DATA_IN.
interface logiana_host_master_if;
    logic       h_nwr;
    logic       h_nrd;
    logic       h_mode;
    logic [7:0] h_data_out;
    logic       h_data_oe;
    logic [7:0] h_data_in;

    modport master (
        output h_nwr, h_nrd, h_mode, h_data_out, h_data_oe,
        input  h_data_in
    );

    modport slave (
        input  h_nwr, h_nrd, h_mode, h_data_out, h_data_oe,
        output h_data_in
    );
endinterface

// File: rtl/logiana_strobe_timer.sv
// Loadable 4-bit down-counter with zero flag; times SETUP, STROBE and GAP phases.
module logiana_strobe_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= 4'd0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == 4'd0);
endmodule

// File: rtl/logiana_host_master.sv
// Bus-master end of the logiana host port: single-byte writes and read bursts
// streamed out on a valid/ready interface. All host pins are registered.
//
//   state   | meaning
//   IDLE    | CMD_READY high, waiting for a command
//   SETUP   | mode/data settle before the first strobe
//   STROBE  | nWR or nRD low; read data captured on the last cycle
//   HOLD    | write only: nWR high, data still driven
//   WAIT_RD | read byte presented on RD_*, waiting for RD_READY
//   GAP     | strobes high, bus released, before next strobe or IDLE
module logiana_host_master
    import logiana_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int STRB_CYCLES  = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic        CLK24,
    input  logic        nRESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WR,
    input  logic        CMD_MODE,
    input  logic [7:0]  CMD_DATA,
    input  logic [15:0] CMD_LEN,
    output logic [7:0]  RD_DATA,
    output logic        RD_VALID,
    input  logic        RD_READY,
    output logic        DONE,
    logiana_host_master_if.master host
);
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
        $error("logiana_host_master: SETUP_CYCLES must be 1..15");
    end
    if (STRB_CYCLES < 1 || STRB_CYCLES > 15) begin : g_bad_strb
        $error("logiana_host_master: STRB_CYCLES must be 1..15");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("logiana_host_master: GAP_CYCLES must be 1..15");
    end

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STRB_LD  = 4'(STRB_CYCLES - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic        mode_q, mode_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        nwr_q, nwr_d;
    logic        nrd_q, nrd_d;
    logic        oe_q, oe_d;

    logic        tmr_load, tmr_dec, tmr_zero;
    logic [3:0]  tmr_val;

    logiana_strobe_timer u_timer (
        .clk      (CLK24),
        .rst_n    (nRESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        mode_d     = mode_q;
        data_d     = data_q;
        rem_d      = rem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = 4'd0;
        tmr_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID && ready_q) begin
                    wr_d   = CMD_WR;
                    mode_d = CMD_MODE;
                    data_d = CMD_DATA;
                    rem_d  = CMD_LEN;
                    if (!CMD_WR && CMD_LEN == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STRB_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_STROBE: begin
                if (tmr_zero) begin
                    if (wr_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d    = ST_WAIT_RD;
                        rd_data_d  = host.h_data_in;
                        rd_valid_d = 1'b1;
                        if (rem_q != 16'd0)
                            rem_d = rem_q - 16'd1;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d  = ST_GAP;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            ST_WAIT_RD: begin
                if (rd_valid_q && RD_READY) begin
                    rd_valid_d = 1'b0;
                    state_d    = ST_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = GAP_LD;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (!wr_q && rem_q != 16'd0) begin
                        state_d  = ST_STROBE;
                        tmr_load = 1'b1;
                        tmr_val  = STRB_LD;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin values follow the next state so every host pin comes straight off a flop.
        nwr_d   = !(state_d == ST_STROBE && wr_d);
        nrd_d   = !(state_d == ST_STROBE && !wr_d);
        oe_d    = wr_d && (state_d == ST_SETUP || state_d == ST_STROBE ||
                           state_d == ST_HOLD);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK24) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            mode_q     <= MODE_CTRL;
            data_q     <= 8'd0;
            rem_q      <= 16'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            nwr_q      <= 1'b1;
            nrd_q      <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            nwr_q      <= nwr_d;
            nrd_q      <= nrd_d;
            oe_q       <= oe_d;
        end
    end

    assign CMD_READY       = ready_q;
    assign RD_DATA         = rd_data_q;
    assign RD_VALID        = rd_valid_q;
    assign DONE            = done_q;
    assign host.h_nwr      = nwr_q;
    assign host.h_nrd      = nrd_q;
    assign host.h_mode     = mode_q;
    assign host.h_data_out = data_q;
    assign host.h_data_oe  = oe_q;
endmodule

// File: tb/tb_logiana_host_master.sv
// Directed bench for logiana_host_master with default timing parameters and a
// simple read responder returning 0xA1, 0xA2, ... on successive nRD falls.
module tb_logiana_host_master;
    import logiana_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic        cmd_mode = 1'b0;
    logic [7:0]  cmd_data = 8'd0;
    logic [15:0] cmd_len = 16'd0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        done;

    int n_chk = 0;
    int n_fail = 0;
    logic prev_mode = MODE_CTRL;

    logiana_host_master_if host ();

    logiana_host_master dut (
        .CLK24     (clk),
        .nRESET    (nreset),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_WR    (cmd_wr),
        .CMD_MODE  (cmd_mode),
        .CMD_DATA  (cmd_data),
        .CMD_LEN   (cmd_len),
        .RD_DATA   (rd_data),
        .RD_VALID  (rd_valid),
        .RD_READY  (rd_ready),
        .DONE      (done),
        .host      (host.master)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {nWR, OE, DONE, READY} for the six cycles after a write handshake.
    task automatic do_write(input logic mode, input logic [7:0] data);
        logic [3:0] exp_tbl [6] = '{4'b1100, 4'b0100, 4'b1100, 4'b1000, 4'b1011, 4'b1001};
        chk("wr_ready_before", 32'(cmd_ready), 32'd1);
        chk("wr_mode_before", 32'(host.h_mode), 32'(prev_mode));
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_mode  = mode;
        cmd_data  = data;
        cmd_len   = 16'hBEEF;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("wr_c%0d_nwr", c + 1), 32'(host.h_nwr), 32'(exp_tbl[c][3]));
            chk($sformatf("wr_c%0d_oe", c + 1), 32'(host.h_data_oe), 32'(exp_tbl[c][2]));
            chk($sformatf("wr_c%0d_done", c + 1), 32'(done), 32'(exp_tbl[c][1]));
            chk($sformatf("wr_c%0d_ready", c + 1), 32'(cmd_ready), 32'(exp_tbl[c][0]));
            chk($sformatf("wr_c%0d_nrd", c + 1), 32'(host.h_nrd), 32'd1);
            chk($sformatf("wr_c%0d_mode", c + 1), 32'(host.h_mode), 32'(mode));
            if (exp_tbl[c][2])
                chk($sformatf("wr_c%0d_data", c + 1), 32'(host.h_data_out), 32'(data));
            tick();
        end
        prev_mode = mode;
    endtask

    task automatic do_read(input logic [15:0] len, input int stall_byte, input int stall_n,
                           output int done_cyc);
        int falls = 0, got = 0, dones = 0, bad_w = 0, ovr = 0, oe_bad = 0, both = 0;
        int low_run = 0, stall_left = stall_n, post = 0;
        logic prev_nrd = 1'b1;
        logic [7:0] exp_b;
        done_cyc = -1;
        chk("rd_ready_before", 32'(cmd_ready), 32'd1);
        host.h_data_in = 8'h00;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_mode  = MODE_CTRL;
        cmd_data  = 8'h77;
        cmd_len   = len;
        rd_ready  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!host.h_nrd) begin
                low_run++;
                if (prev_nrd) begin
                    falls++;
                    host.h_data_in = 8'(160 + falls);
                end
            end else if (!prev_nrd) begin
                if (low_run != 1) bad_w++;
                low_run = 0;
            end
            prev_nrd = host.h_nrd;
            if (host.h_data_oe) oe_bad++;
            if (!host.h_nwr) oe_bad++;
            if (!host.h_nwr && !host.h_nrd) both++;
            if (rd_valid && !host.h_nrd) ovr++;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (rd_valid) begin
                exp_b = 8'(160 + got + 1);
                if (got + 1 == stall_byte && stall_left > 0) begin
                    rd_ready = 1'b0;
                    stall_left--;
                    chk("rd_stall_data", 32'(rd_data), 32'(exp_b));
                end else begin
                    rd_ready = 1'b1;
                    chk($sformatf("rd_byte%0d", got + 1), 32'(rd_data), 32'(exp_b));
                    got++;
                end
            end else begin
                rd_ready = 1'b1;
            end
            if (dones > 0) post++;
            if (post > 3) break;
            tick();
        end
        rd_ready = 1'b1;
        chk("rd_nrd_falls", 32'(falls), 32'(len));
        chk("rd_bytes", 32'(got), 32'(len));
        chk("rd_done_count", 32'(dones), 32'd1);
        chk("rd_strobe_width", 32'(bad_w), 32'd0);
        chk("rd_overrun", 32'(ovr), 32'd0);
        chk("rd_oe_or_nwr", 32'(oe_bad), 32'd0);
        chk("rd_both_low", 32'(both), 32'd0);
        chk("rd_stall_used", 32'(stall_left), 32'd0);
        chk("rd_mode_idle", 32'(host.h_mode), 32'(MODE_CTRL));
        prev_mode = MODE_CTRL;
    endtask

    initial begin
        int dc;
        host.h_data_in = 8'h00;
        nreset = 1'b0;
        tick();
        tick();
        chk("rst_nwr", 32'(host.h_nwr), 32'd1);
        chk("rst_nrd", 32'(host.h_nrd), 32'd1);
        chk("rst_mode", 32'(host.h_mode), 32'd0);
        chk("rst_dout", 32'(host.h_data_out), 32'd0);
        chk("rst_oe", 32'(host.h_data_oe), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        nreset = 1'b1;
        tick();
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        do_write(MODE_CTRL, 8'h12);
        do_write(MODE_TRIG, 8'h00);
        tick();
        tick();
        chk("mode_held_idle", 32'(host.h_mode), 32'(MODE_TRIG));

        do_read(16'd4, 0, 0, dc);
        chk("rd4_done_cycle", 32'(dc), 32'd13);

        do_read(16'd4, 2, 5, dc);
        chk("rd4_stall_done_cycle", 32'(dc), 32'd18);

        do_read(16'd0, 0, 0, dc);
        chk("rd0_done_cycle", 32'(dc), 32'd0);

        // Reset while nWR is low.
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_mode  = MODE_TRIG;
        cmd_data  = 8'hC3;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rr_strobe_low", 32'(host.h_nwr), 32'd0);
        nreset = 1'b0;
        tick();
        chk("rr_nwr", 32'(host.h_nwr), 32'd1);
        chk("rr_oe", 32'(host.h_data_oe), 32'd0);
        chk("rr_done", 32'(done), 32'd0);
        chk("rr_ready", 32'(cmd_ready), 32'd0);
        tick();
        nreset = 1'b1;
        tick();
        chk("rr_done_after", 32'(done), 32'd0);
        chk("rr_ready_after", 32'(cmd_ready), 32'd1);
        prev_mode = MODE_CTRL;
        do_write(MODE_CTRL, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
